// File: rtl/bpred_perf_counters.sv
// Branch-prediction statistics unit: samples the M-stage predictor outcome
// flags for each committing instruction and counts them in eight counters.
// The counters are read and written through a CSR-style port, and each one
// has its own count inhibit and a sticky overflow flag.
module bpred_perf_counters #(
  parameter int CNT_WIDTH = 32,
  parameter int NUM_CNT   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallW,
  input  logic                 FlushW,
  input  logic                 InstrValidM,
  input  logic [3:0]           IClassM,
  input  logic                 BPWrongM,
  input  logic                 BPDirWrongM,
  input  logic                 BTAWrongM,
  input  logic                 RASPredPCWrongM,
  input  logic                 IClassWrongM,
  input  logic [NUM_CNT-1:0]   CntInhibit,
  input  logic                 WrEn,
  input  logic [2:0]           WrAddr,
  input  logic [CNT_WIDTH-1:0] WrData,
  input  logic                 RdEn,
  input  logic [2:0]           RdAddr,
  output logic [CNT_WIDTH-1:0] RdData,
  output logic                 RdValid,
  output logic [NUM_CNT-1:0]   OvfFlags
);

  logic                 commitM;
  logic [NUM_CNT-1:0]   evM;
  logic [NUM_CNT-1:0]   evW;
  logic [CNT_WIDTH-1:0] cnt    [NUM_CNT];
  logic [CNT_WIDTH:0]   incVal [NUM_CNT];

  // Increment with the carry-out kept in the top bit, so the caller can
  // detect a wrap from all-ones to zero.
  function automatic logic [CNT_WIDTH:0] incWrap(input logic [CNT_WIDTH-1:0] v);
    return {1'b0, v} + (CNT_WIDTH+1)'(1);
  endfunction

  assign commitM = InstrValidM & ~StallW & ~FlushW;

  // Map the predictor outcome flags onto the counter event slots.
  always_comb begin
    evM    = '0;
    evM[0] = IClassM[0];
    evM[1] = IClassM[0] & BPDirWrongM;
    evM[2] = IClassM[1] | IClassM[3];
    evM[3] = BTAWrongM;
    evM[4] = IClassM[2];
    evM[5] = RASPredPCWrongM;
    evM[6] = IClassWrongM;
    evM[7] = BPWrongM;
  end

  // --- stage 1: M -> W event register ---
  // No enable: an instruction stalled in M is captured only on its commit edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) evW <= '0;
    else        evW <= commitM ? evM : '0;
  end

  // Precompute each counter's incremented value together with its carry-out.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) incVal[i] = incWrap(cnt[i]);
  end

  // --- stage 2: counter update ---
  // A write takes priority over an increment; the event is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
      OvfFlags <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (WrEn && (WrAddr == 3'(i))) begin
          cnt[i]      <= WrData;
          OvfFlags[i] <= 1'b0;
        end else if (evW[i] && !CntInhibit[i]) begin
          cnt[i] <= incVal[i][CNT_WIDTH-1:0];
          if (incVal[i][CNT_WIDTH]) OvfFlags[i] <= 1'b1;
        end
      end
    end
  end

  // Registered read: returns the counter value before this edge's update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RdData  <= '0;
      RdValid <= 1'b0;
    end else begin
      RdValid <= RdEn;
      if (RdEn) RdData <= cnt[RdAddr];
    end
  end

endmodule

// File: tb/tb_bpred_perf_counters.sv
// Testbench for bpred_perf_counters. A reference model tracks the counter
// values and flags from the event rules, and the directed scenarios add
// hand-computed literal checks.
module tb_bpred_perf_counters;

  localparam int W = 32;
  localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         StallW = 0, FlushW = 0, InstrValidM = 0;
  logic [3:0]   IClassM = '0;
  logic         BPWrongM = 0, BPDirWrongM = 0, BTAWrongM = 0;
  logic         RASPredPCWrongM = 0, IClassWrongM = 0;
  logic [7:0]   CntInhibit = '0;
  logic         WrEn = 0;
  logic [2:0]   WrAddr = '0;
  logic [W-1:0] WrData = '0;
  logic         RdEn = 0;
  logic [2:0]   RdAddr = '0;
  logic [W-1:0] RdData;
  logic         RdValid;
  logic [7:0]   OvfFlags;

  int errors = 0;
  int checks = 0;

  bpred_perf_counters #(.CNT_WIDTH(W), .NUM_CNT(8)) dut (
    .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW),
    .InstrValidM(InstrValidM), .IClassM(IClassM), .BPWrongM(BPWrongM),
    .BPDirWrongM(BPDirWrongM), .BTAWrongM(BTAWrongM),
    .RASPredPCWrongM(RASPredPCWrongM), .IClassWrongM(IClassWrongM),
    .CntInhibit(CntInhibit), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdEn(RdEn), .RdAddr(RdAddr), .RdData(RdData), .RdValid(RdValid),
    .OvfFlags(OvfFlags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doRead(input logic [2:0] a, input longint unsigned exp, input string nm);
    RdEn = 1'b1;
    RdAddr = a;
    tick();
    chk({nm, "_valid"}, RdValid, 1);
    chk({nm, "_data"}, RdData, exp);
    RdEn = 1'b0;
    tick();
    chk({nm, "_pulse"}, RdValid, 0);
  endtask

  task automatic doWrite(input logic [2:0] a, input logic [W-1:0] d);
    WrEn = 1'b1;
    WrAddr = a;
    WrData = d;
    tick();
    WrEn = 1'b0;
  endtask

  // Reference model. State is what the outputs and counters should be after
  // the most recent rising edge; pend holds the events committed at that edge,
  // which are counted on the following edge.
  longint unsigned mCnt [8];
  logic [7:0]      mOvf = '0;
  logic [7:0]      mPend = '0;
  longint unsigned mRd = 0;
  logic            mRv = 1'b0;

  initial begin
    for (int i = 0; i < 8; i++) mCnt[i] = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < 8; i++) mCnt[i] = 0;
        mOvf = '0; mPend = '0; mRd = 0; mRv = 1'b0;
        chk("mdl_rst_rd", RdData, 0);
        chk("mdl_rst_rv", RdValid, 0);
        chk("mdl_rst_ovf", OvfFlags, 0);
      end else begin
        logic [7:0]      ev;
        longint unsigned nRd;
        chk("mdl_rdvalid", RdValid, mRv);
        chk("mdl_rddata", RdData, mRd);
        chk("mdl_ovf", OvfFlags, mOvf);
        nRd = RdEn ? mCnt[RdAddr] : mRd;
        mRv = RdEn;
        mRd = nRd;
        for (int i = 0; i < 8; i++) begin
          if (WrEn && WrAddr == 3'(i)) begin
            mCnt[i] = WrData;
            mOvf[i] = 1'b0;
          end else if (mPend[i] && !CntInhibit[i]) begin
            if (mCnt[i] == MAXV) begin
              mCnt[i] = 0;
              mOvf[i] = 1'b1;
            end else begin
              mCnt[i] = mCnt[i] + 1;
            end
          end
        end
        ev[0] = IClassM[0];
        ev[1] = IClassM[0] && BPDirWrongM;
        ev[2] = IClassM[1] || IClassM[3];
        ev[3] = BTAWrongM;
        ev[4] = IClassM[2];
        ev[5] = RASPredPCWrongM;
        ev[6] = IClassWrongM;
        ev[7] = BPWrongM;
        mPend = (InstrValidM && !StallW && !FlushW) ? ev : 8'h00;
      end
    end
  end

  initial begin
    #1;
    chk("init_rd", RdData, 0);
    chk("init_rv", RdValid, 0);
    chk("init_ovf", OvfFlags, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Five committed branches, the first two with a wrong direction.
    for (int k = 0; k < 5; k++) begin
      InstrValidM = 1'b1;
      IClassM = 4'b0001;
      BPDirWrongM = (k < 2);
      tick();
    end
    InstrValidM = 1'b0; IClassM = '0; BPDirWrongM = 1'b0;
    tick();
    doRead(3'd0, 5, "br_cnt");
    doRead(3'd1, 2, "dir_cnt");

    // A branch stalled for four cycles still counts only once.
    InstrValidM = 1'b1; IClassM = 4'b0001; StallW = 1'b1;
    repeat (4) tick();
    StallW = 1'b0;
    tick();
    InstrValidM = 1'b0; IClassM = '0;
    tick(); tick();
    doRead(3'd0, 6, "stall_once");

    // A stalled branch flushed on release is not counted.
    InstrValidM = 1'b1; IClassM = 4'b0001; StallW = 1'b1;
    repeat (4) tick();
    StallW = 1'b0; FlushW = 1'b1;
    tick();
    InstrValidM = 1'b0; IClassM = '0; FlushW = 1'b0;
    tick(); tick();
    doRead(3'd0, 6, "flush_drop");

    // Wrap from all-ones sets the sticky overflow flag; a write clears it.
    doWrite(3'd7, 32'hFFFF_FFFF);
    InstrValidM = 1'b1; BPWrongM = 1'b1;
    tick();
    InstrValidM = 1'b0; BPWrongM = 1'b0;
    tick();
    chk("wrap_ovf_set", OvfFlags[7], 1);
    doRead(3'd7, 0, "wrap_zero");
    doWrite(3'd7, 32'd3);
    chk("wrap_ovf_clr", OvfFlags[7], 0);
    doRead(3'd7, 3, "wr_after_wrap");

    // A write to the counter that is incrementing in the same cycle wins.
    InstrValidM = 1'b1; IClassM = 4'b0100;
    tick();
    InstrValidM = 1'b0; IClassM = '0;
    WrEn = 1'b1; WrAddr = 3'd4; WrData = 32'd10;
    tick();
    WrEn = 1'b0;
    tick();
    doRead(3'd4, 10, "wr_beats_inc");

    // Inhibit on counter 0 only: branches lost, dir-wrong still counted.
    CntInhibit = 8'h01;
    InstrValidM = 1'b1; IClassM = 4'b0001; BPDirWrongM = 1'b1;
    repeat (3) tick();
    InstrValidM = 1'b0; IClassM = '0; BPDirWrongM = 1'b0;
    tick();
    CntInhibit = 8'h00;
    tick();
    doRead(3'd0, 6, "inh_br");
    doRead(3'd1, 5, "inh_dir");

    // Multi-hot class: jump slot counts once; call also has no other slot.
    InstrValidM = 1'b1; IClassM = 4'b1010;
    tick();
    InstrValidM = 1'b0; IClassM = '0;
    tick(); tick();
    doRead(3'd2, 1, "multi_jump");

    // Asynchronous reset mid-cycle with state and a read pulse in flight.
    doWrite(3'd7, 32'hFFFF_FFFF);
    InstrValidM = 1'b1; BPWrongM = 1'b1;
    tick();
    InstrValidM = 1'b0; BPWrongM = 1'b0;
    tick();
    chk("pre_rst_ovf", OvfFlags[7], 1);
    RdEn = 1'b1; RdAddr = 3'd0;
    tick();
    RdEn = 1'b0;
    chk("pre_rst_rv", RdValid, 1);
    chk("pre_rst_rd", RdData, 6);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_rd", RdData, 0);
    chk("arst_rv", RdValid, 0);
    chk("arst_ovf", OvfFlags, 0);
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) doRead(3'(i), 0, "post_rst");

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
